// File: rtl/video_timing_480p.sv
// CEA-861 720x480p raster generator: counters plus a one-cycle registered decode of the next position.
// Outputs update one clock after each enabled edge; en=0 freezes the raster, holds outputs and suppresses pulses.
module video_timing_480p #(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 62,
    parameter int H_BP     = 60,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 9,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 30,
    parameter int SYNC_POL = 0,
    parameter int PREFETCH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       pix_req
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
    localparam logic [10:0] HA     = 11'(H_ACTIVE);
    localparam logic [10:0] VA     = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] PF     = 11'(PREFETCH);
    localparam logic        SYNC_ON = (SYNC_POL != 0);

    logic [9:0]  nh;
    logic [9:0]  nv;
    logic [9:0]  pv;
    logic [10:0] ph;
    logic        n_de;
    logic        n_hs;
    logic        n_vs;
    logic        n_req;

    // x/y double as the raster counters; everything else decodes the position they step to.
    always_comb begin
        nh = x + 10'd1;
        nv = y;
        if (x == H_LAST) begin
            nh = '0;
            nv = (y == V_LAST) ? '0 : y + 10'd1;
        end

        // Prefetch position may spill past the line end onto the next line.
        ph = {1'b0, nh} + PF;
        pv = nv;
        if (ph >= H_TOT) begin
            ph = ph - H_TOT;
            pv = (nv == V_LAST) ? '0 : nv + 10'd1;
        end

        n_de  = ({1'b0, nh} < HA) && ({1'b0, nv} < VA);
        n_hs  = ({1'b0, nh} >= HS_BEG) && ({1'b0, nh} < HS_END);
        n_vs  = ({1'b0, nv} >= VS_BEG) && ({1'b0, nv} < VS_END);
        n_req = (ph < HA) && ({1'b0, pv} < VA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= H_LAST;
            y           <= V_LAST;
            de          <= 1'b0;
            pix_req     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hs          <= ~SYNC_ON;
            vs          <= ~SYNC_ON;
        end else if (en) begin
            x           <= nh;
            y           <= nv;
            de          <= n_de;
            pix_req     <= n_req;
            line_start  <= (nh == '0);
            frame_start <= (nh == '0) && (nv == '0);
            hs          <= n_hs ? SYNC_ON : ~SYNC_ON;
            vs          <= n_vs ? SYNC_ON : ~SYNC_ON;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_480p.sv
// Bench for video_timing_480p: default 480p instance plus a shrunken active-high-sync instance
// small enough to run whole frames, both checked every cycle against a position-arithmetic model.
module tb_video_timing_480p;

    typedef struct packed {
        int ha; int hf; int hsw; int hb;
        int va; int vf; int vsw; int vb;
        int pol; int pf;
    } cfg_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic       pr;
        logic [9:0] x;
        logic [9:0] y;
    } out_t;

    localparam cfg_t C0 = '{ha: 720, hf: 16, hsw: 62, hb: 60, va: 480, vf: 9, vsw: 6, vb: 30, pol: 0, pf: 2};
    localparam cfg_t C1 = '{ha: 20, hf: 3, hsw: 4, hb: 5, va: 6, vf: 2, vsw: 2, vb: 3, pol: 1, pf: 3};

    logic clk;
    logic rst;
    logic en;

    logic       hs0, vs0, de0, ls0, fs0, pr0;
    logic [9:0] x0, y0;
    logic       hs1, vs1, de1, ls1, fs1, pr1;
    logic [9:0] x1, y1;

    int n_cmp = 0;
    int n_bad = 0;

    video_timing_480p dut0 (
        .clk(clk), .reset(rst), .en(en),
        .hs(hs0), .vs(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0), .pix_req(pr0)
    );

    video_timing_480p #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1), .PREFETCH(3)
    ) dut1 (
        .clk(clk), .reset(rst), .en(en),
        .hs(hs1), .vs(vs1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1), .pix_req(pr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic cfg_t cf(input int k);
        return (k == 0) ? C0 : C1;
    endfunction

    function automatic int htot(input cfg_t c);
        return c.ha + c.hf + c.hsw + c.hb;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.va + c.vf + c.vsw + c.vb;
    endfunction

    // Model state: raster position, "no enabled edge since reset", and "last edge was enabled".
    int m_h[2];
    int m_v[2];
    bit m_fresh[2];
    bit m_pe[2];

    always @(posedge clk or posedge rst) begin : model
        cfg_t c;
        int ht, vt, p;
        for (int k = 0; k < 2; k++) begin
            c  = cf(k);
            ht = htot(c);
            vt = vtot(c);
            if (rst) begin
                m_h[k]     <= ht - 1;
                m_v[k]     <= vt - 1;
                m_fresh[k] <= 1'b1;
                m_pe[k]    <= 1'b0;
            end else if (en) begin
                p = (m_v[k] * ht + m_h[k] + 1) % (ht * vt);
                m_h[k]     <= p % ht;
                m_v[k]     <= p / ht;
                m_fresh[k] <= 1'b0;
                m_pe[k]    <= 1'b1;
            end else begin
                m_pe[k] <= 1'b0;
            end
        end
    end

    function automatic out_t model_out(input int k);
        cfg_t c;
        out_t o;
        int ht, vt, h, v, p;
        c  = cf(k);
        ht = htot(c);
        vt = vtot(c);
        h  = m_h[k];
        v  = m_v[k];
        o.x  = 10'(h);
        o.y  = 10'(v);
        o.de = (h < c.ha) && (v < c.va);
        o.hs = ((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hsw)) ? c.pol[0] : ~c.pol[0];
        o.vs = ((v >= c.va + c.vf) && (v < c.va + c.vf + c.vsw)) ? c.pol[0] : ~c.pol[0];
        p    = (v * ht + h + c.pf) % (ht * vt);
        o.pr = !m_fresh[k] && ((p % ht) < c.ha) && ((p / ht) < c.va);
        o.ls = m_pe[k] && (h == 0);
        o.fs = m_pe[k] && (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare both instances against the model.
    task automatic tick();
        out_t g;
        out_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? {hs0, vs0, de0, ls0, fs0, pr0, x0, y0}
                         : {hs1, vs1, de1, ls1, fs1, pr1, x1, y1};
            e = model_out(k);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL model_d%0d t=%0t got hs%b vs%b de%b ls%b fs%b pr%b x%0d y%0d expected hs%b vs%b de%b ls%b fs%b pr%b x%0d y%0d",
                         k, $time, g.hs, g.vs, g.de, g.ls, g.fs, g.pr, g.x, g.y,
                         e.hs, e.vs, e.de, e.ls, e.fs, e.pr, e.x, e.y);
            end
        end
    endtask

    initial begin
        int fs_a, fs_b, de1n, ls1n, vs1n, vsx, vsy, pr1r, de0n, hs0n, hsx, pr0x, pr0y;
        int stall_pulses, found;
        logic pp0, pp1, en_used;

        rst = 1'b0;
        en  = 1'b1;
        #1 rst = 1'b1;
        tick(); tick(); tick();

        chk("rst_hs0", hs0, 1);
        chk("rst_vs0", vs0, 1);
        chk("rst_de0", de0, 0);
        chk("rst_x0", x0, 857);
        chk("rst_y0", y0, 524);
        chk("rst_pr0", pr0, 0);
        chk("rst_ls0", ls0, 0);
        chk("rst_fs0", fs0, 0);
        chk("rst_x1", x1, 31);
        chk("rst_y1", y1, 12);
        chk("rst_hs1", hs1, 0);

        rst = 1'b0;
        tick();
        chk("start_x0", x0, 0);
        chk("start_y0", y0, 0);
        chk("start_de0", de0, 1);
        chk("start_ls0", ls0, 1);
        chk("start_fs0", fs0, 1);
        chk("start_pr0", pr0, 1);
        chk("start_fs1", fs1, 1);

        // Census over the first 1716 enabled cycles (two default lines, four small frames).
        fs_a = -1; fs_b = -1; de1n = 0; ls1n = 0; vs1n = 0; vsx = -1; vsy = -1; pr1r = 0;
        de0n = 0; hs0n = 0; hsx = -1; pr0x = -1; pr0y = -1;
        pp0 = pr0;
        pp1 = pr1;
        for (int c = 0; c < 1716; c++) begin
            if (fs1) begin
                if (fs_a < 0) fs_a = c;
                else if (fs_b < 0) fs_b = c;
            end
            if (c < 416) begin
                de1n += int'(de1);
                ls1n += int'(ls1);
                if (pr1 && !pp1) pr1r++;
                if (vs1) begin
                    vs1n++;
                    if (vsx < 0) begin vsx = x1; vsy = y1; end
                end
            end
            if (c < 858) begin
                de0n += int'(de0);
                if (!hs0) begin
                    hs0n++;
                    if (hsx < 0) hsx = x0;
                end
            end
            if (pr0 && !pp0 && pr0x < 0) begin pr0x = x0; pr0y = y0; end
            pp0 = pr0;
            pp1 = pr1;
            tick();
        end
        chk("d0_de_per_line", de0n, 720);
        chk("d0_hs_width", hs0n, 62);
        chk("d0_hs_first_x", hsx, 736);
        chk("d0_pr_rise_x", pr0x, 856);
        chk("d0_pr_rise_y", pr0y, 0);
        chk("d1_de_per_frame", de1n, 120);
        chk("d1_ls_per_frame", ls1n, 13);
        chk("d1_frame_period", fs_b - fs_a, 416);
        chk("d1_vs_cycles", vs1n, 64);
        chk("d1_vs_first_x", vsx, 0);
        chk("d1_vs_first_y", vsy, 8);
        chk("d1_pr_rises", pr1r, 6);

        // Random stalls: model keeps checking every cycle; pulses must vanish on stalled edges.
        stall_pulses = 0;
        for (int i = 0; i < 3000; i++) begin
            en_used = ($urandom_range(0, 99) >= 30);
            en = en_used;
            tick();
            if (!en_used) stall_pulses += int'(ls0) + int'(fs0) + int'(ls1) + int'(fs1);
        end
        chk("stall_pulses", stall_pulses, 0);

        // Mid-line reset, asserted between clock edges.
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            if (x0 == 10'd400) begin found = 1; break; end
            tick();
        end
        chk("found_x400", found, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_x0", x0, 857);
        chk("async_y0", y0, 524);
        chk("async_de0", de0, 0);
        chk("async_hs0", hs0, 1);
        chk("async_vs0", vs0, 1);
        chk("async_x1", x1, 31);
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b0;
        tick();
        tick();
        chk("held_fs0", fs0, 0);
        chk("held_x0", x0, 857);
        en = 1'b1;
        tick();
        chk("restart_fs0", fs0, 1);
        chk("restart_x0", x0, 0);
        chk("restart_y0", y0, 0);
        chk("restart_fs1", fs1, 1);
        for (int i = 0; i < 100; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
